// File: rtl/if_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | if_fetch_unit: PC sequencer feeding a 2-entry {pc, instr} fetch FIFO     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] irom_addr,
  input  logic [31:0]           irom_data,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [31:0]           out_pc,
  output logic                  misalign_err
);

  logic [31:0] pc;
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic [31:0] ent_pc    [2];
  logic [31:0] ent_instr [2];
  logic        pop;
  logic        push;

  assign irom_addr = pc[ADDR_WIDTH+1:2];
  assign out_valid = (count != 2'd0);
  assign out_pc    = out_valid ? ent_pc[rd_ptr]    : 32'd0;
  assign out_instr = out_valid ? ent_instr[rd_ptr] : 32'd0;

  // A redirect kills any handshake in the same cycle, so decode never sees it complete.
  assign pop  = out_valid && out_ready && !redirect_valid;
  assign push = !redirect_valid && ((count != 2'd2) || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc           <= RESET_PC;
      count        <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      misalign_err <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        ent_pc[i]    <= 32'd0;
        ent_instr[i] <= 32'd0;
      end
    end else begin
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        pc     <= {redirect_pc[31:2], 2'b00};
      end else begin
        if (push) begin
          ent_pc[wr_ptr]    <= pc;
          ent_instr[wr_ptr] <= irom_data;
          wr_ptr            <= ~wr_ptr;
          pc                <= pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// Testbench for if_fetch_unit: directed scenarios plus a randomized run against a queue model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  irom_addr;
  logic [31:0] irom_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_err;

  logic [31:0] rom [256];
  int total = 0;
  int bad   = 0;

  assign irom_data = rom[irom_addr];

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .irom_addr(irom_addr), .irom_data(irom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .misalign_err(misalign_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at posedge+1 with reset just released; no edge has pushed yet.
  task automatic do_reset();
    redirect_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (out_pc !== 32'd0) begin bad++; $display("FAIL rst_pc got=%h exp=0", out_pc); end
    total++; if (out_instr !== 32'd0) begin bad++; $display("FAIL rst_instr got=%h exp=0", out_instr); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL rst_mis got=%b exp=0", misalign_err); end
    total++; if (irom_addr !== 8'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", irom_addr); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_c0_valid got=%b exp=0", out_valid); end
    for (int k = 0; k < 8; k++) begin
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, out_valid); end
      total++; if (out_pc !== 32'(4 * k)) begin bad++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, out_pc, 32'(4 * k)); end
      total++; if (out_instr !== rom[k]) begin bad++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, out_instr, rom[k]); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
    total++; if (irom_addr !== 8'd2) begin bad++; $display("FAIL bp_addr got=%0d exp=2", irom_addr); end
    total++; if (out_pc !== 32'd0) begin bad++; $display("FAIL bp_head_pc got=%h exp=0", out_pc); end
    total++; if (out_instr !== rom[0]) begin bad++; $display("FAIL bp_head_instr got=%h exp=%h", out_instr, rom[0]); end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++; if (out_pc !== 32'(4 * k)) begin bad++; $display("FAIL bp_drain_pc k=%0d got=%h exp=%h", k, out_pc, 32'(4 * k)); end
      total++; if (out_instr !== rom[k]) begin bad++; $display("FAIL bp_drain_instr k=%0d got=%h exp=%h", k, out_instr, rom[k]); end
      tick();
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    do_reset();
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    out_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_n1_valid got=%b exp=0", out_valid); end
    total++; if (irom_addr !== 8'd16) begin bad++; $display("FAIL redir_n1_addr got=%0d exp=16", irom_addr); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL redir_aligned_mis got=%b exp=0", misalign_err); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL redir_n2_valid got=%b exp=1", out_valid); end
    total++; if (out_pc !== 32'h40) begin bad++; $display("FAIL redir_n2_pc got=%h exp=40", out_pc); end
    total++; if (out_instr !== rom[16]) begin bad++; $display("FAIL redir_n2_instr got=%h exp=%h", out_instr, rom[16]); end
    tick();
    total++; if (out_pc !== 32'h44) begin bad++; $display("FAIL redir_n3_pc got=%h exp=44", out_pc); end
  endtask

  task automatic test_misalign();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    tick();
    redirect_valid = 1'b0;
    total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL mis_pulse got=%b exp=1", misalign_err); end
    tick();
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b exp=0", misalign_err); end
    total++; if (out_pc !== 32'h40) begin bad++; $display("FAIL mis_pc got=%h exp=40", out_pc); end
  endtask

  task automatic test_wrap();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3FC;
    tick();
    redirect_valid = 1'b0;
    total++; if (irom_addr !== 8'd255) begin bad++; $display("FAIL wrap_addr255 got=%0d exp=255", irom_addr); end
    tick();
    total++; if (out_pc !== 32'h3FC) begin bad++; $display("FAIL wrap_pc3fc got=%h exp=3fc", out_pc); end
    total++; if (irom_addr !== 8'd0) begin bad++; $display("FAIL wrap_addr0 got=%0d exp=0", irom_addr); end
    tick();
    total++; if (out_pc !== 32'h400) begin bad++; $display("FAIL wrap_pc400 got=%h exp=400", out_pc); end
    total++; if (out_instr !== rom[0]) begin bad++; $display("FAIL wrap_instr got=%h exp=%h", out_instr, rom[0]); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    total++; if (out_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap32_top got=%h exp=fffffffc", out_pc); end
    total++; if (out_instr !== rom[255]) begin bad++; $display("FAIL wrap32_instr got=%h exp=%h", out_instr, rom[255]); end
    tick();
    total++; if (out_pc !== 32'd0) begin bad++; $display("FAIL wrap32_zero got=%h exp=0", out_pc); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    repeat (3) tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid got=%b exp=1", out_valid); end
    #2 rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
    total++; if (irom_addr !== 8'd0) begin bad++; $display("FAIL rmid_addr got=%0d exp=0", irom_addr); end
    tick();
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_restart_valid got=%b exp=1", out_valid); end
    total++; if (out_pc !== 32'd0) begin bad++; $display("FAIL rmid_restart_pc got=%h exp=0", out_pc); end
  endtask

  // Random traffic against a queue model of the fetch contract.
  task automatic test_random();
    logic [63:0] q[$];
    logic [31:0] m_pc;
    logic        m_mis;
    logic        rv;
    logic        rdy;
    logic        do_pop;
    logic        do_push;
    logic [31:0] rpc;
    do_reset();
    q     = {};
    m_pc  = 32'd0;
    m_mis = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 11) == 0);
      rpc = $urandom();
      if ($urandom_range(0, 1) == 1) rpc = rpc & 32'h0000_03FF;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      total++; if (out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, q.size() != 0); end
      total++; if (irom_addr !== m_pc[9:2]) begin bad++; $display("FAIL rnd_addr c=%0d got=%0d exp=%0d", c, irom_addr, m_pc[9:2]); end
      total++; if (misalign_err !== m_mis) begin bad++; $display("FAIL rnd_mis c=%0d got=%b exp=%b", c, misalign_err, m_mis); end
      if (q.size() != 0) begin
        total++; if (out_pc !== q[0][63:32]) begin bad++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, out_pc, q[0][63:32]); end
        total++; if (out_instr !== q[0][31:0]) begin bad++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", c, out_instr, q[0][31:0]); end
      end
      do_pop  = (q.size() != 0) && rdy && !rv;
      do_push = !rv && ((q.size() < 2) || do_pop);
      if (rv) begin
        q     = {};
        m_mis = (rpc[1:0] != 2'b00);
        m_pc  = {rpc[31:2], 2'b00};
      end else begin
        m_mis = 1'b0;
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          q.push_back({m_pc, rom[m_pc[9:2]]});
          m_pc = m_pc + 32'd4;
        end
      end
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
